seq_mul_shift_add: RTL and testbench



---
 rtl/seq_mul_shift_add_pkg.sv | 23 ++
 rtl/yAdder.sv | 22 ++
 rtl/seq_mul_shift_add.sv | 99 +++++++++
 tb/tb_seq_mul_shift_add.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_shift_add_pkg.sv
// Shared arithmetic-datapath definitions for the iterative shift-add multiplier.
// Holds the control state encoding and the default operand/counter widths.
package seq_mul_shift_add_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // The unused encoding 2'b11 is folded onto IDLE so the FSM always recovers.
    function automatic state_t state_decode(input logic [1:0] s);
        case (s)
            2'b01:   state_decode = CALC;
            2'b10:   state_decode = DONE;
            default: state_decode = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/yAdder.sv
// 32-bit ripple-carry adder shared by the arithmetic datapath.
// z = a + b + cin, with the carry out of bit 31 on cout.
module yAdder (
    output logic [31:0] z,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);

    logic [32:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign z[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[32];

endmodule

// File: rtl/seq_mul_shift_add.sv
// Iterative unsigned WIDTH x WIDTH multiplier, one shift-add step per clock
// through the shared yAdder, with valid/ready handshakes on both sides.
module seq_mul_shift_add
    import seq_mul_shift_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               hi_nonzero
);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   prod_q;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     sum;
    logic                 carry;
    logic [2*WIDTH-1:0]   p_step;
    logic                 accept;
    logic                 last_step;

    // Add M into the high half only when the multiplier bit under P[0] is set.
    assign add_b = p_q[0] ? m_q : '0;

    yAdder u_add (
        .z    (sum),
        .cout (carry),
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .cin  (1'b0)
    );

    // Carry becomes the new MSB so P_hi + M is never truncated.
    assign p_step    = {carry, sum, p_q[WIDTH-1:1]};
    assign accept    = in_valid & in_ready;
    assign last_step = (state_decode(state_q) == CALC) && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_decode(state_q);
        case (state_decode(state_q))
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_decode(state_q))
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else if (accept) begin
            m_q   <= a;
            p_q   <= {{WIDTH{1'b0}}, b};
            cnt_q <= CNT_W'(WIDTH);
        end else if (state_decode(state_q) == CALC) begin
            p_q   <= p_step;
            cnt_q <= cnt_q - CNT_W'(1);
            // Result is latched separately so it survives the next operand load.
            if (last_step) prod_q <= p_step;
        end
    end

    assign product    = prod_q;
    assign hi_nonzero = |prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Scoreboard bench for seq_mul_shift_add: driver pushes a*b expectations,
// a negedge monitor pops and checks products, latency and output hold.
module tb_seq_mul_shift_add;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  product;
    logic            hi_nonzero;

    seq_mul_shift_add dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .product    (product),
        .hi_nonzero (hi_nonzero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        longint       exp_cyc;
    } txn_t;

    txn_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    int     rdy_mode = 2;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // out_ready: 0 = always high, 1 = random, 2 = held low
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: pops on each output handshake, checks latency on the rising
    // edge of out_valid and product stability while stalled.
    logic           pv, pr;
    logic [2*W-1:0] held;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            logic [63:0] exp;
            txn_t        t;
            if (out_valid) chk("in_ready_in_done", 64'(in_ready), 64'd0);
            if (out_valid && !pv) begin
                if (sb.size() == 0) chk("spurious_valid", 64'd1, 64'd0);
                else chk("latency", 64'(cyc), 64'(sb[0].exp_cyc));
            end
            if (out_valid && pv && !pr) chk("hold_product", product, held);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_output", 64'd1, 64'd0);
                end else begin
                    t   = sb.pop_front();
                    exp = 64'(t.a) * 64'(t.b);
                    chk("product", product, exp);
                    chk("hi_nonzero", 64'(hi_nonzero), 64'(exp[63:32] != 32'd0));
                end
            end
            pv   = out_valid;
            pr   = out_ready;
            held = product;
        end
    end

    // Present operands until accepted; returns the cycle number of the accept edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input int gap,
                        output longint acc_cyc);
        txn_t t;
        acc_cyc = -1;
        repeat (gap) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = x;
        b = y;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                t.a = x;
                t.b = y;
                t.exp_cyc = cyc + 1 + W;
                sb.push_back(t);
                acc_cyc = cyc + 1;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                a = $urandom;
                b = $urandom;
                return;
            end
        end
        chk("accept_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) return;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        longint acc, t0;
        logic [W-1:0] x, y;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_product", product, 64'd0);
        chk("rst_hi_nonzero", 64'(hi_nonzero), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdy_mode = 0;

        // Reset in the middle of a calculation
        send(32'd7, 32'd9, 1, acc);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_product", product, 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'd3, 32'd4, 1, acc);
        wait_drain();

        // Directed corner operands
        send(32'd6, 32'd7, 2, acc);
        wait_drain();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, acc);
        wait_drain();
        send(32'd0, 32'hDEAD_BEEF, 1, acc);
        wait_drain();
        send(32'h1234_5678, 32'd1, 1, acc);
        wait_drain();

        // Backpressure with new operands held pending
        rdy_mode = 2;
        send(32'd5, 32'd6, 1, acc);
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        chk("bp_reached_done", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 32'd9;
        b = 32'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_product", product, 64'd30);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        t0 = cyc;
        rdy_mode = 0;
        send(32'd9, 32'd9, 0, acc);
        chk("bp_accept_cycle", 64'(acc), 64'(t0 + 3));
        wait_drain();

        // Randomized traffic with gaps on both sides
        rdy_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            case ($urandom_range(0, 7))
                0:       x = '0;
                1:       x = '1;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = '1;
                default: y = $urandom;
            endcase
            send(x, y, int'($urandom_range(0, 3)), acc);
        end
        rdy_mode = 0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
